// File: rtl/aes_round_iter.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock, on-the-fly key expansion, valid/ready on both sides.
// Optional block counter output blk_count is enabled by defining AES_ROUND_ITER_STAT_EN.
module aes_round_iter #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
`ifdef AES_ROUND_ITER_STAT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
    $error("aes_round_iter: UNROLL must be 1, 2, 5 or 10");
  end

  // The RUN cycle whose first round is LAST_RND finishes round 10.
  localparam logic [3:0] LAST_RND = 4'(11 - UNROLL);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  rk_q, rk_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [127:0]  st_last, rk_last;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as a^254 (0 maps to 0), followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t = a;
    for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), a);
    inv = gmul(t, t);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   m  [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      m[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      m[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      m[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      m[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = last ? sr[i] : m[i];
    return o ^ rk;
  endfunction

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    logic [127:0] st_in, rk_in, st_o, rk_o;
    logic [3:0]   rnd_w;
    if (gi == 0) begin : g_head
      assign st_in = st_q;
      assign rk_in = rk_q;
    end else begin : g_chain
      assign st_in = g_round[gi-1].st_o;
      assign rk_in = g_round[gi-1].rk_o;
    end
    assign rnd_w = rnd_q + 4'(gi);
    assign rk_o  = key_exp(rk_in, rcon(rnd_w));
    assign st_o  = enc_round(st_in, rk_o, rnd_w == 4'd10);
  end

  assign st_last = g_round[UNROLL-1].st_o;
  assign rk_last = g_round[UNROLL-1].rk_o;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = RUN;
          st_d    = data_in ^ key_in;
          rk_d    = key_in;
          rnd_d   = 4'd1;
        end
      end
      RUN: begin
        st_d  = st_last;
        rk_d  = rk_last;
        rnd_d = rnd_q + 4'(UNROLL);
        if (rnd_q == LAST_RND) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = st_q;

`ifdef AES_ROUND_ITER_STAT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) blk_cnt_q <= '0;
    else if (out_valid && out_ready) blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blk_count = blk_cnt_q;
`endif

endmodule
